alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Initiator side of the ALU operand/opcode interface (A, B, UC in; RESULT, FLAGS out).
- Accepts operation commands over a valid/ready handshake and drives the registered operands and opcode to the ALU.
- Waits a programmable settle time, then captures RESULT/FLAGS and returns them over a valid/ready response handshake.
- One operation in flight at a time; sits between the control/test logic and the ALU instance.

Parameters:
- N, 4, operand/result width; must match the ALU's N.
- SETTLE_CYCLES, 1, cycles operands are held stable at the ALU before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_a  input  N  operand A.
- cmd_b  input  N  operand B.
- cmd_op  input  3  opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 illegal.
- alu_a  output  N  to ALU A.
- alu_b  output  N  to ALU B.
- alu_uc  output  3  to ALU UC.
- alu_result  input  N  from ALU RESULT.
- alu_flags  input  4  from ALU FLAGS.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  N  captured result.
- rsp_flags  output  4  captured flags.
- rsp_op  output  3  opcode of this response.
- rsp_err  output  1  1 = illegal opcode, no ALU operation performed.
- busy  output  1  state != IDLE.
- done_count  output  8  completed responses, saturating at 255.

Behaviour:
- Reset: one clock with rst=1 forces state IDLE. All registered outputs go to 0: alu_a, alu_b, alu_uc, rsp_*, done_count.
- cmd_ready = (state==IDLE) && !rst.
- An in-flight operation or pending response is discarded on reset; no response is produced for it.
- FSM states: IDLE, SETTLE, RESP.
- IDLE: when cmd_valid&&cmd_ready at edge E0:
  - cmd_op != 7: latch cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_uc; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - cmd_op == 7: alu_* unchanged; load rsp_result=0, rsp_flags=0, rsp_op=7, rsp_err=1; go to RESP. rsp_valid is visible after E0.
- SETTLE: the counter decrements each edge while nonzero. On the edge where the counter==0:
  - capture alu_result into rsp_result and alu_flags into rsp_flags;
  - set rsp_op=alu_uc, rsp_err=0;
  - go to RESP.
- Capture latency: capture occurs at edge E0+SETTLE_CYCLES, and rsp_valid is first high in the following cycle. With the default, the response is visible 1 cycle after the accept edge plus one settle cycle.
- RESP:
  - rsp_valid=1; rsp_* held stable until the handshake.
  - At the edge with rsp_valid&&rsp_ready: go to IDLE and increment done_count, saturating at 255.
  - cmd_ready rises in the cycle after the handshake. No same-edge command accept.
- alu_a/alu_b/alu_uc hold their last values in IDLE and RESP; they change only on a legal accept.
- rsp_valid is 0 in IDLE and SETTLE.
- cmd_* are ignored when cmd_ready=0. cmd_valid may drop without a handshake.
- rsp_ready held high continuously gives back-to-back throughput of one op per SETTLE_CYCLES+2 cycles.
- Widths: no arithmetic in this block beyond the 4-bit settle counter and the 8-bit saturating done_count; result and flag data pass through unmodified.

Test Plan:
- Reset then add: cmd_a=3, cmd_b=5, cmd_op=0, rsp_ready=1, real ALU attached. Required:
  - alu_a=3, alu_b=5, alu_uc=0 the cycle after accept;
  - rsp_valid rises 2 cycles after the accept edge with rsp_result=8, rsp_op=0, rsp_err=0;
  - done_count=1.
- Backpressure, stub ALU driving alu_result=4'hA, alu_flags=4'b1010: rsp_ready=0 for 5 cycles. Required:
  - rsp_valid stays high with rsp_result=A, rsp_flags=1010 stable;
  - cmd_ready=0 throughout;
  - after rsp_ready=1, cmd_ready=1 in the next cycle.
- Illegal op: cmd_op=7, cmd_a=9. Required:
  - rsp_valid the cycle after accept, rsp_err=1, rsp_result=0, rsp_flags=0;
  - alu_* keep their previous values.
- SETTLE_CYCLES=4, sub 7-2: the stub changes alu_result at cycles 1..3 after accept and holds 5 from cycle 3. Required: rsp_result=5, captured at the accept edge +4.
- Reset mid-operation: assert rst during SETTLE. Required:
  - no rsp_valid is produced;
  - all outputs are 0 the cycle after reset;
  - cmd_ready=1 once rst deasserts.
- Saturation: 260 completed ops. Required: done_count reads 255 and stays 255.

Source files
------------

// File: rtl/alu_sequencer.sv
// Initiator for the ALU operand/opcode interface. Holds one command at the ALU,
// waits a programmable settle time, then returns the captured RESULT/FLAGS.
module alu_sequencer #(
  parameter int N             = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [2:0]   cmd_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_uc,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [2:0]   rsp_op,
  output logic         rsp_err,
  output logic         busy,
  output logic [7:0]   done_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  typedef struct packed {
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic [2:0]   op;
    logic         err;
  } rsp_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] OP_ILL   = 3'd7;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  rsp_t       rsp_q;
  logic       accept;

  assign cmd_ready  = (state == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign rsp_result = rsp_q.result;
  assign rsp_flags  = rsp_q.flags;
  assign rsp_op     = rsp_q.op;
  assign rsp_err    = rsp_q.err;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (cmd_op == OP_ILL) ? RESP : SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_uc     <= '0;
      rsp_q      <= '0;
      done_count <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          // Illegal opcodes never reach the ALU; answer immediately with an error.
          if (cmd_op != OP_ILL) begin
            alu_a  <= cmd_a;
            alu_b  <= cmd_b;
            alu_uc <= cmd_op;
            cnt    <= CNT_INIT;
          end else begin
            rsp_q <= '{result: '0, flags: 4'd0, op: OP_ILL, err: 1'b1};
          end
        end
        SETTLE: begin
          if (cnt == 4'd0)
            rsp_q <= '{result: alu_result, flags: alu_flags, op: alu_uc, err: 1'b0};
          else
            cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready && done_count != 8'hFF) done_count <= done_count + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table on a behavioural ALU plus
// hand-written backpressure, settle, reset and saturation sequences.
module tb_alu_sequencer;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with default settle time
  logic         rst1, cv1, cr1, rv1, rr1, rerr1, busy1;
  logic [N-1:0] ca1, cb1, aa1, ab1, ares1, rres1;
  logic [2:0]   cop1, auc1, rop1;
  logic [3:0]   afl1, rfl1;
  logic [7:0]   dc1;

  // Instance with a four-cycle settle time
  logic         rst4, cv4, cr4, rv4, rr4, rerr4, busy4;
  logic [N-1:0] ca4, cb4, aa4, ab4, ares4, rres4;
  logic [2:0]   cop4, auc4, rop4;
  logic [3:0]   afl4, rfl4;
  logic [7:0]   dc4;

  logic         use_stub;
  logic [N-1:0] stub_res, mres;
  logic [3:0]   stub_fl;

  always_comb begin
    case (auc1)
      3'd0:    mres = aa1 + ab1;
      3'd1:    mres = aa1 - ab1;
      3'd2:    mres = aa1 & ab1;
      3'd3:    mres = aa1 | ab1;
      3'd4:    mres = aa1 ^ ab1;
      3'd5:    mres = aa1 << ab1;
      3'd6:    mres = aa1 >> ab1;
      default: mres = '0;
    endcase
  end
  // Behavioural ALU flags: bit2 = negative, bit0 = zero
  assign ares1 = use_stub ? stub_res : mres;
  assign afl1  = use_stub ? stub_fl : {1'b0, mres[N-1], 1'b0, (mres == '0)};

  alu_sequencer #(.N(N), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .cmd_valid(cv1), .cmd_ready(cr1),
    .cmd_a(ca1), .cmd_b(cb1), .cmd_op(cop1),
    .alu_a(aa1), .alu_b(ab1), .alu_uc(auc1),
    .alu_result(ares1), .alu_flags(afl1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_result(rres1), .rsp_flags(rfl1),
    .rsp_op(rop1), .rsp_err(rerr1), .busy(busy1), .done_count(dc1)
  );

  alu_sequencer #(.N(N), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .cmd_valid(cv4), .cmd_ready(cr4),
    .cmd_a(ca4), .cmd_b(cb4), .cmd_op(cop4),
    .alu_a(aa4), .alu_b(ab4), .alu_uc(auc4),
    .alu_result(ares4), .alu_flags(afl4),
    .rsp_valid(rv4), .rsp_ready(rr4), .rsp_result(rres4), .rsp_flags(rfl4),
    .rsp_op(rop4), .rsp_err(rerr4), .busy(busy4), .done_count(dc4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic send1(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    int t = 0;
    while (!cr1 && t < 50) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cr1, 1);
    ca1 = a; cb1 = b; cop1 = op; cv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cv1 = 1'b0;
  endtask

  // Latency counted in cycles after the accept edge.
  task automatic wait_rsp1(output int lat);
    lat = 1;
    while (!rv1 && lat < 50) begin @(negedge clk); lat++; end
  endtask

  typedef struct {
    logic [N-1:0] a, b;
    logic [2:0]   op;
    logic [N-1:0] res;
    logic [3:0]   fl;
    logic         err;
    int           lat;
  } vec_t;

  vec_t tbl[9];
  int lat;
  logic [N-1:0] pa, pb;
  logic [2:0] puc;
  logic early;

  initial begin
    tbl[0] = '{4'd3,  4'd5,  3'd0, 4'h8, 4'b0100, 1'b0, 2};
    tbl[1] = '{4'd7,  4'd2,  3'd1, 4'h5, 4'b0000, 1'b0, 2};
    tbl[2] = '{4'hC,  4'hA,  3'd2, 4'h8, 4'b0100, 1'b0, 2};
    tbl[3] = '{4'd1,  4'd4,  3'd3, 4'h5, 4'b0000, 1'b0, 2};
    tbl[4] = '{4'd6,  4'd6,  3'd4, 4'h0, 4'b0001, 1'b0, 2};
    tbl[5] = '{4'd3,  4'd2,  3'd5, 4'hC, 4'b0100, 1'b0, 2};
    tbl[6] = '{4'd9,  4'd7,  3'd7, 4'h0, 4'b0000, 1'b1, 1};
    tbl[7] = '{4'd9,  4'd1,  3'd6, 4'h4, 4'b0000, 1'b0, 2};
    tbl[8] = '{4'hF,  4'd1,  3'd0, 4'h0, 4'b0001, 1'b0, 2};

    rst1 = 1; rst4 = 1; cv1 = 0; cv4 = 0; rr1 = 1; rr4 = 1;
    ca1 = 0; cb1 = 0; cop1 = 0; ca4 = 0; cb4 = 0; cop4 = 0;
    use_stub = 0; stub_res = 0; stub_fl = 0; ares4 = 0; afl4 = 4'b0011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cr1, 0);
    chk("rst_rsp_valid", rv1, 0);
    chk("rst_alu_a", aa1, 0);
    chk("rst_done_count", dc1, 0);
    chk("rst_busy", busy1, 0);
    rst1 = 0; rst4 = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cr1, 1);

    // Vector table on the behavioural ALU
    pa = 0; pb = 0; puc = 0;
    for (int i = 0; i < 9; i++) begin
      send1(tbl[i].a, tbl[i].b, tbl[i].op);
      if (tbl[i].op != 3'd7) begin pa = tbl[i].a; pb = tbl[i].b; puc = tbl[i].op; end
      chk($sformatf("v%0d_alu_a", i), aa1, pa);
      chk($sformatf("v%0d_alu_b", i), ab1, pb);
      chk($sformatf("v%0d_alu_uc", i), auc1, puc);
      chk($sformatf("v%0d_busy", i), busy1, 1);
      wait_rsp1(lat);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_result", i), rres1, tbl[i].res);
      chk($sformatf("v%0d_flags", i), rfl1, tbl[i].fl);
      chk($sformatf("v%0d_op", i), rop1, tbl[i].op);
      chk($sformatf("v%0d_err", i), rerr1, tbl[i].err);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_drop", i), rv1, 0);
      chk($sformatf("v%0d_done_count", i), dc1, i + 1);
      chk($sformatf("v%0d_cmd_ready", i), cr1, 1);
    end

    // Backpressure with a stub ALU; stub changes after capture must not leak through
    use_stub = 1; stub_res = 4'hA; stub_fl = 4'b1010; rr1 = 0;
    send1(4'd1, 4'd1, 3'd0);
    wait_rsp1(lat);
    chk("bp_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), rv1, 1);
      chk($sformatf("bp%0d_result", k), rres1, 4'hA);
      chk($sformatf("bp%0d_flags", k), rfl1, 4'b1010);
      chk($sformatf("bp%0d_cmd_ready", k), cr1, 0);
      stub_res = 4'h3; stub_fl = 4'b0101;
      @(negedge clk);
    end
    rr1 = 1;
    @(negedge clk);
    chk("bp_cmd_ready_after", cr1, 1);
    chk("bp_rsp_valid_after", rv1, 0);
    chk("bp_done_count", dc1, 10);

    // Four-cycle settle: only the value present at accept+4 may be captured
    ca4 = 4'd7; cb4 = 4'd2; cop4 = 3'd1; cv4 = 1;
    chk("s4_cmd_ready", cr4, 1);
    @(posedge clk);
    @(negedge clk);
    cv4 = 0;
    chk("s4_alu_a", aa4, 7);
    chk("s4_alu_b", ab4, 2);
    chk("s4_alu_uc", auc4, 1);
    early = 0;
    for (int k = 1; k <= 4; k++) begin
      if (rv4) early = 1;
      ares4 = (k == 1) ? 4'd1 : (k == 2) ? 4'd2 : 4'd5;
      @(negedge clk);
    end
    chk("s4_no_early_valid", early, 0);
    chk("s4_valid", rv4, 1);
    chk("s4_result", rres4, 5);
    chk("s4_flags", rfl4, 4'b0011);
    chk("s4_op", rop4, 1);
    chk("s4_err", rerr4, 0);
    @(negedge clk);
    chk("s4_done_count", dc4, 1);
    chk("s4_cmd_ready_after", cr4, 1);

    // Reset while settling discards the operation
    stub_res = 4'h7; stub_fl = 4'b1111;
    send1(4'd4, 4'd4, 3'd1);
    rst1 = 1;
    @(negedge clk);
    chk("mr_rsp_valid", rv1, 0);
    chk("mr_alu_a", aa1, 0);
    chk("mr_alu_b", ab1, 0);
    chk("mr_alu_uc", auc1, 0);
    chk("mr_rsp_result", rres1, 0);
    chk("mr_rsp_flags", rfl1, 0);
    chk("mr_rsp_op", rop1, 0);
    chk("mr_rsp_err", rerr1, 0);
    chk("mr_done_count", dc1, 0);
    chk("mr_busy", busy1, 0);
    chk("mr_cmd_ready_in_rst", cr1, 0);
    rst1 = 0;
    @(negedge clk);
    chk("mr_cmd_ready", cr1, 1);
    early = 0;
    for (int k = 0; k < 4; k++) begin
      if (rv1) early = 1;
      @(negedge clk);
    end
    chk("mr_no_rsp", early, 0);

    // Saturation of done_count
    use_stub = 0;
    for (int i = 1; i <= 260; i++) begin
      send1(4'd1, 4'd1, 3'd0);
      wait_rsp1(lat);
      if (lat >= 50) chk("sat_rsp_timeout", lat, 2);
      @(negedge clk);
      if (i == 254) chk("sat_254", dc1, 254);
      if (i >= 255) chk($sformatf("sat_%0d", i), dc1, 255);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
